fwd_ctrl: RTL

FWD_CTRL -- requirements
Module: fwd_ctrl

---
 rtl/fwd_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fwd_ctrl.sv
// rtl/fwd_ctrl.sv - operand forwarding select and load-use hazard control
//
// Tracks the instruction in EX and the one in WB. From these it picks the
// source of each decode-stage operand and raises a pipeline stall when a
// needed value is not yet available.
//
// Build option: FWD_CTRL_BYPASS_EN
//   defined   - ALU (EX) and DATAD (WB) bypass paths are used; only a
//               load-use dependency stalls, for one cycle.
//   undefined - no bypass; operands come only from REG/PC/IMM and any
//               EX or WB dependency on a consumed source stalls.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   id_valid_i          decode instruction valid
//   id_rs1_i, id_rs2_i  decode source indices
//   id_use_pc_i         operand A is PC
//   id_use_imm_i        operand B is immediate
//   id_rd_i, id_we_i    decode destination index and write enable
//   id_load_i           decode instruction is a load
//   flush_i             kill decode instruction
//   asel_o              operand A select: 00 REG, 01 PC, 10 ALU, 11 DATAD
//   bsel_o              operand B select: 00 REG, 01 IMM, 10 ALU, 11 DATAD
//   stall_o             hold PC/decode, inject bubble into EX
//   stall_cnt_o         saturating stall-cycle counter

module fwd_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_use_pc_i,
  input  logic        id_use_imm_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_we_i,
  input  logic        id_load_i,
  input  logic        flush_i,
  output logic [1:0]  asel_o,
  output logic [1:0]  bsel_o,
  output logic        stall_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_PC    = 2'b01;
  localparam logic [1:0] SEL_IMM   = 2'b01;
  localparam logic [1:0] SEL_ALU   = 2'b10;
  localparam logic [1:0] SEL_DATAD = 2'b11;

  logic [4:0]  r_ex_rd;
  logic        r_ex_we;
  logic        r_ex_ld;
  logic [4:0]  r_wb_rd;
  logic        r_wb_we;
  logic [15:0] r_stall_cnt;

  logic w_ex_hit_a;
  logic w_ex_hit_b;
  logic w_wb_hit_a;
  logic w_wb_hit_b;
  logic w_use_a;
  logic w_use_b;
  logic w_ld_use;
  logic w_hazard;
  logic w_stall;
  logic w_issue;

  // x0 is hardwired zero, so it can never be a forwarding target.
  always_comb begin
    w_ex_hit_a = r_ex_we && (r_ex_rd == id_rs1_i) && (id_rs1_i != 5'd0);
    w_ex_hit_b = r_ex_we && (r_ex_rd == id_rs2_i) && (id_rs2_i != 5'd0);
    w_wb_hit_a = r_wb_we && (r_wb_rd == id_rs1_i) && (id_rs1_i != 5'd0);
    w_wb_hit_b = r_wb_we && (r_wb_rd == id_rs2_i) && (id_rs2_i != 5'd0);
    // A source only matters when the operand mux actually reads the register.
    w_use_a    = ~id_use_pc_i;
    w_use_b    = ~id_use_imm_i;
    w_ld_use   = r_ex_ld && ((w_use_a && w_ex_hit_a) || (w_use_b && w_ex_hit_b));
  end

`ifdef FWD_CTRL_BYPASS_EN
  // EX result is the newest value, so it beats WB on the same register.
  always_comb begin
    asel_o = SEL_REG;
    bsel_o = SEL_REG;
    if (id_use_pc_i)     asel_o = SEL_PC;
    else if (w_ex_hit_a) asel_o = SEL_ALU;
    else if (w_wb_hit_a) asel_o = SEL_DATAD;
    if (id_use_imm_i)    bsel_o = SEL_IMM;
    else if (w_ex_hit_b) bsel_o = SEL_ALU;
    else if (w_wb_hit_b) bsel_o = SEL_DATAD;
    // Load data only exists at WB, so an EX-stage load cannot be bypassed.
    w_hazard = id_valid_i && w_ld_use;
  end
`else
  always_comb begin
    asel_o = id_use_pc_i  ? SEL_PC  : SEL_REG;
    bsel_o = id_use_imm_i ? SEL_IMM : SEL_REG;
    // Load-use is a subset of the EX-hit term; kept so both builds share it.
    w_hazard = id_valid_i &&
               (w_ld_use ||
                (w_use_a && (w_ex_hit_a || w_wb_hit_a)) ||
                (w_use_b && (w_ex_hit_b || w_wb_hit_b)));
  end
`endif

  // A flushed decode instruction is dead, so it can never be stalled.
  assign w_stall     = w_hazard & ~flush_i;
  assign w_issue     = id_valid_i & ~w_stall & ~flush_i;
  assign stall_o     = w_stall;
  assign stall_cnt_o = r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rd     <= 5'd0;
      r_ex_we     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_we     <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_wb_rd <= r_ex_rd;
      r_wb_we <= r_ex_we;
      if (w_issue) begin
        r_ex_rd <= id_rd_i;
        r_ex_we <= id_we_i;
        r_ex_ld <= id_load_i;
      end else begin
        r_ex_rd <= 5'd0;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
      end
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

endmodule
